sample_player: RTL

- Playback-side consumer of the sample-rate strobe from the rate counter.
- On each sample tick, fetches the next sample from a synchronous sample RAM and presents it to the audio output path over a valid/ready handshake.
- Supports one-shot and looped playback of a programmable-length clip starting at address 0.
- Sits between the rate counter, the sample RAM read port and the audio codec interface.

---
 rtl/sample_player.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sample_player.sv
// Sample-rate driven clip player: fetches one RAM word per tick and offers it over valid/ready.
// Define SAMPLE_PLAYER_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
`timescale 1ns/1ps
module sample_player #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  sample_tick,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done
`ifdef SAMPLE_PLAYER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]            underrun_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, READ, CAPTURE, PRESENT} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    rd_q, rd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    play_prev_q;
  logic                    start;

  assign start = play & ~play_prev_q;

  // Dropping play wins over everything else, including a same-cycle acceptance.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    rd_d     = 1'b0;
    done_d   = 1'b0;
    if (state_q != IDLE && !play) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              len_d   = length;
              addr_d  = '0;
              state_d = WAIT_TICK;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        WAIT_TICK: begin
          if (sample_tick) begin
            rd_d    = 1'b1;
            state_d = READ;
          end
        end
        READ: state_d = CAPTURE;
        CAPTURE: begin
          sample_d = mem_rdata;
          valid_d  = 1'b1;
          state_d  = PRESENT;
        end
        PRESENT: begin
          valid_d = 1'b1;
          if (sample_ready) begin
            valid_d = 1'b0;
            if (addr_q != len_q - ADDR_ONE) begin
              addr_d  = addr_q + ADDR_ONE;
              state_d = WAIT_TICK;
            end else if (loop) begin
              addr_d  = '0;
              state_d = WAIT_TICK;
            end else begin
              addr_d  = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      rd_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      play_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      play_prev_q <= play;
    end
  end

  assign mem_rd       = rd_q;
  assign mem_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef SAMPLE_PLAYER_UNDERRUN_CNT_EN
  logic [7:0] urun_q, urun_d;

  // A tick that lands while a fetch is still in flight is a missed sample period.
  always_comb begin
    urun_d = urun_q;
    if (start) begin
      urun_d = '0;
    end else if (sample_tick && (state_q inside {READ, CAPTURE, PRESENT}) && urun_q != 8'hFF) begin
      urun_d = urun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      urun_q <= '0;
    end else begin
      urun_q <= urun_d;
    end
  end

  assign underrun_cnt = urun_q;
`endif

endmodule
